// File: rtl/ascon_round_counter.sv
// Round counter for the ASCON permutation datapath.
// Loads one of NUM_MODES start values on a start request, then counts up one
// round per enabled cycle until LAST_VALUE is consumed, pulsing done_o.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; cpt_o keeps the last loaded/reached value
// RUN   | counting rounds; en_i advances, abort_i cancels without done_o
module ascon_round_counter #(
  parameter int                         WIDTH      = 4,
  parameter int                         NUM_MODES  = 2,
  parameter logic [NUM_MODES*WIDTH-1:0] INIT_VEC   = {4'd6, 4'd0},
  parameter logic [WIDTH-1:0]           LAST_VALUE = 11,
  parameter int                         MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              en_i,
  input  logic              abort_i,
  output logic [WIDTH-1:0]  cpt_o,
  output logic              busy_o,
  output logic              last_o,
  output logic              done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cpt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] init_val;
  logic             at_last;

  // Start value for the requested mode; out-of-range modes fall back to mode 0.
  always_comb begin
    init_val = INIT_VEC[WIDTH-1:0];
    for (int m = 0; m < NUM_MODES; m++) begin
      if (int'(mode_i) == m) begin
        init_val = INIT_VEC[m*WIDTH +: WIDTH];
      end
    end
  end

  // Terminal-round compare, driven only by registers.
  always_comb begin
    at_last = (cpt == LAST_VALUE);
  end

  // Control FSM with registered count, busy and done outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cpt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort_i has priority so a coincident start is dropped
          if (start_i && !abort_i) begin
            cpt   <= init_val;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (en_i) begin
            if (at_last) begin
              // count stays at LAST_VALUE so the final index remains visible
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cpt <= cpt + 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign cpt_o  = cpt;
  assign busy_o = busy;
  assign done_o = done;
  assign last_o = busy & at_last;

endmodule

// File: tb/tb_ascon_round_counter.sv
// Directed bench for ascon_round_counter: default ASCON configuration plus a
// narrow 3-mode instance that exercises wrap-around and out-of-range modes.
module tb_ascon_round_counter;

  logic clk;
  logic rst;

  logic       start, en, abort;
  logic [0:0] mode;
  logic [3:0] cpt;
  logic       busy, last, done;

  logic       start2, en2, abort2;
  logic [1:0] mode2;
  logic [2:0] cpt2;
  logic       busy2, last2, done2;

  int errors;
  int checks;

  ascon_round_counter dut (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .mode_i  (mode),
    .en_i    (en),
    .abort_i (abort),
    .cpt_o   (cpt),
    .busy_o  (busy),
    .last_o  (last),
    .done_o  (done)
  );

  ascon_round_counter #(
    .WIDTH      (3),
    .NUM_MODES  (3),
    .INIT_VEC   ({3'd6, 3'd2, 3'd0}),
    .LAST_VALUE (3'd4)
  ) dut2 (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start2),
    .mode_i  (mode2),
    .en_i    (en2),
    .abort_i (abort2),
    .cpt_o   (cpt2),
    .busy_o  (busy2),
    .last_o  (last2),
    .done_o  (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cpt !== 4'd0)  begin errors++; $display("FAIL reset_cpt got=%0d exp=0", cpt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (last !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_last_done got=%b%b exp=00", last, done); end
    checks++; if (cpt2 !== 3'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got cpt=%0d busy=%b exp 0 0", cpt2, busy2); end
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0 || cpt !== 4'd0) begin errors++; $display("FAIL idle_after_reset got busy=%b cpt=%0d exp 0 0", busy, cpt); end
    // mid-run asynchronous reset
    start = 1'b1; mode = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++; if (cpt !== 4'd8 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset_run got cpt=%0d busy=%b exp 8 1", cpt, busy); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (cpt !== 4'd0 || busy !== 1'b0 || last !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL async_reset got cpt=%0d busy=%b last=%b done=%b exp 0 0 0 0", cpt, busy, last, done); end
    step();
    rst = 1'b0;
    en = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_async got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_mode0_run();
    int done_cnt;
    done_cnt = 0;
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (cpt !== 4'(i) || busy !== 1'b1 || last !== (i == 11))
        begin errors++; $display("FAIL mode0_step%0d got cpt=%0d busy=%b last=%b exp cpt=%0d busy=1 last=%b", i, cpt, busy, last, i, (i == 11)); end
      if (done === 1'b1) done_cnt++;
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cpt !== 4'd11 || last !== 1'b0)
      begin errors++; $display("FAIL mode0_done got done=%b busy=%b cpt=%0d last=%b exp 1 0 11 0", done, busy, cpt, last); end
    done_cnt += (done === 1'b1) ? 1 : 0;
    step();
    if (done === 1'b1) done_cnt++;
    step();
    if (done === 1'b1) done_cnt++;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mode0_done_count got=%0d exp=1", done_cnt); end
    checks++; if (cpt !== 4'd11 || busy !== 1'b0) begin errors++; $display("FAIL mode0_hold got cpt=%0d busy=%b exp 11 0", cpt, busy); end
    en = 1'b0;
  endtask

  task automatic test_mode1_stall();
    start = 1'b1; mode = 1'b1; en = 1'b0;
    step();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      en = 1'b0;
      checks++; if (cpt !== 4'(6 + j) || busy !== 1'b1 || done !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got cpt=%0d busy=%b done=%b exp cpt=%0d 1 0", j, cpt, busy, done, 6 + j); end
      step();
      en = 1'b1;
      checks++; if (cpt !== 4'(6 + j) || last !== (j == 5))
        begin errors++; $display("FAIL stall_en%0d got cpt=%0d last=%b exp cpt=%0d last=%b", j, cpt, last, 6 + j, (j == 5)); end
      step();
    end
    en = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cpt !== 4'd11)
      begin errors++; $display("FAIL stall_done got done=%b busy=%b cpt=%0d exp 1 0 11", done, busy, cpt); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_clear got=%b exp=0", done); end
  endtask

  task automatic test_abort();
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++; if (cpt !== 4'd3) begin errors++; $display("FAIL abort_pre got cpt=%0d exp=3", cpt); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || cpt !== 4'd3 || done !== 1'b0)
      begin errors++; $display("FAIL abort_idle got busy=%b cpt=%0d done=%b exp 0 3 0", busy, cpt, done); end
    step();
    checks++; if (done !== 1'b0 || cpt !== 4'd3) begin errors++; $display("FAIL abort_no_done got done=%b cpt=%0d exp 0 3", done, cpt); end
    // start blocked by coincident abort
    start = 1'b1; abort = 1'b1; mode = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || cpt !== 4'd3) begin errors++; $display("FAIL start_abort got busy=%b cpt=%0d exp 0 3", busy, cpt); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    step();
    // restart attempt mid-run must be ignored
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    checks++; if (cpt !== 4'd8 || busy !== 1'b1) begin errors++; $display("FAIL midrun_start got cpt=%0d busy=%b exp 8 1", cpt, busy); end
    step(); step(); step(); step();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done got done=%b busy=%b exp 1 0", done, busy); end
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    checks++; if (cpt !== 4'd6 || busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL b2b_restart got cpt=%0d busy=%b done=%b exp 6 1 0", cpt, busy, done); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (done !== 1'b1 || cpt !== 4'd11) begin errors++; $display("FAIL b2b_second_done got done=%b cpt=%0d exp 1 11", done, cpt); end
    en = 1'b0;
    step();
  endtask

  task automatic test_param_sweep();
    logic [2:0] seq [7];
    seq[0] = 3'd6; seq[1] = 3'd7; seq[2] = 3'd0; seq[3] = 3'd1;
    seq[4] = 3'd2; seq[5] = 3'd3; seq[6] = 3'd4;
    start2 = 1'b1; mode2 = 2'd2; en2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (cpt2 !== seq[i] || busy2 !== 1'b1 || last2 !== (i == 6))
        begin errors++; $display("FAIL wrap_step%0d got cpt=%0d busy=%b last=%b exp cpt=%0d busy=1 last=%b", i, cpt2, busy2, last2, seq[i], (i == 6)); end
      step();
    end
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || cpt2 !== 3'd4)
      begin errors++; $display("FAIL wrap_done got done=%b busy=%b cpt=%0d exp 1 0 4", done2, busy2, cpt2); end
    step();
    start2 = 1'b1; mode2 = 2'd3;
    step();
    start2 = 1'b0;
    checks++; if (cpt2 !== 3'd0 || busy2 !== 1'b1) begin errors++; $display("FAIL bad_mode_load got cpt=%0d busy=%b exp 0 1", cpt2, busy2); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (done2 !== 1'b1 || cpt2 !== 3'd4) begin errors++; $display("FAIL bad_mode_done got done=%b cpt=%0d exp 1 4", done2, cpt2); end
    start2 = 1'b1; mode2 = 2'd1;
    step();
    start2 = 1'b0;
    checks++; if (cpt2 !== 3'd2 || busy2 !== 1'b1) begin errors++; $display("FAIL mode1_load got cpt=%0d busy=%b exp 2 1", cpt2, busy2); end
    en2 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0; mode = 1'b0; en = 1'b0; abort = 1'b0;
    start2 = 1'b0; mode2 = 2'd0; en2 = 1'b0; abort2 = 1'b0;
    test_reset();
    test_mode0_run();
    test_mode1_stall();
    test_abort();
    test_back_to_back();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
